// File: rtl/ama_riscv_uart_tx_pkg.sv
// Shared types and constants for the UART transmitter.
// Shifter FSM state encoding, byte width, and the bit-period helper used at elaboration.
package ama_riscv_uart_tx_pkg;

    localparam int UART_DATA_W = 8;

    // One start bit, eight data bits and one stop bit per frame.
    localparam int UART_FRAME_BITS = 10;

    typedef enum logic [1:0] {
        UART_TX_IDLE  = 2'd0,
        UART_TX_START = 2'd1,
        UART_TX_DATA  = 2'd2,
        UART_TX_STOP  = 2'd3
    } uart_tx_state_t;

    function automatic int uart_clocks_per_bit(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/ama_riscv_uart_tx_if.sv
// Valid/ready byte channel from the core's UART_TX store path to the transmitter.
// The master drives data/valid; the slave answers with ready (holding register empty).
interface ama_riscv_uart_tx_if
    import ama_riscv_uart_tx_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W
) ();

    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );

endinterface

// File: rtl/ama_riscv_uart_tx.sv
// 8N1 UART transmitter: 1-entry holding register feeding a start/data/stop shifter.
// Frames go out back-to-back while the holding register is refilled; valid while !ready is dropped.
module ama_riscv_uart_tx
    import ama_riscv_uart_tx_pkg::*;
#(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic                 clk,
    input  logic                 rst,
    ama_riscv_uart_tx_if.slave   uart_send_req,
    output logic                 serial_out,
    output logic                 tx_busy
);

    localparam int CLOCKS_PER_BIT = uart_clocks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int CNT_W          = (CLOCKS_PER_BIT < 2) ? 1 : $clog2(CLOCKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLOCKS_PER_BIT - 1);

    generate
        if (CLOCKS_PER_BIT < 2) begin : g_bad_baud
            $error("ama_riscv_uart_tx: CLOCK_FREQ/BAUD_RATE must be at least 2");
        end
    endgenerate

    uart_tx_state_t         state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic [UART_DATA_W-1:0] hold_q, hold_d;
    logic                   hold_valid_q, hold_valid_d;
    logic                   serial_q, serial_d;

    logic accept;
    logic load;
    logic bit_end;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= UART_TX_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            serial_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            serial_q     <= serial_d;
        end
    end

    // ready comes straight from the flop so there is no path from valid back to ready.
    assign uart_send_req.ready = ~hold_valid_q;
    assign accept              = uart_send_req.valid & ~hold_valid_q;
    assign bit_end             = (cnt_q == CNT_MAX);

    // Next-state and datapath
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        load         = 1'b0;

        unique case (state_q)
            UART_TX_IDLE: begin
                cnt_d = '0;
                if (hold_valid_q) begin
                    load    = 1'b1;
                    state_d = UART_TX_START;
                end
            end
            UART_TX_START: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    state_d = UART_TX_DATA;
                end
            end
            UART_TX_DATA: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    shift_d   = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = UART_TX_STOP;
                    end
                end
            end
            UART_TX_STOP: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    // A waiting byte starts its frame straight out of the stop bit.
                    if (hold_valid_q) begin
                        load    = 1'b1;
                        state_d = UART_TX_START;
                    end else begin
                        state_d = UART_TX_IDLE;
                    end
                end
            end
            default: begin
                state_d = UART_TX_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (load) begin
            shift_d      = hold_q;
            bit_idx_d    = '0;
            hold_valid_d = 1'b0;
        end

        // load needs hold_valid, which blocks accept, so the two never collide.
        if (accept) begin
            hold_d       = uart_send_req.data[UART_DATA_W-1:0];
            hold_valid_d = 1'b1;
        end
    end

    // Outputs: the line level is computed from the next state and registered.
    always_comb begin
        serial_d = 1'b1;
        unique case (state_d)
            UART_TX_IDLE:  serial_d = 1'b1;
            UART_TX_START: serial_d = 1'b0;
            UART_TX_DATA:  serial_d = shift_d[0];
            UART_TX_STOP:  serial_d = 1'b1;
            default:       serial_d = 1'b1;
        endcase
        tx_busy = (state_q != UART_TX_IDLE);
    end

    assign serial_out = serial_q;

endmodule

// File: tb/tb_ama_riscv_uart_tx.sv
// Bench for ama_riscv_uart_tx: a 10-clock/bit instance with a line-decoding scoreboard and a 2-clock/bit instance.
module tb_ama_riscv_uart_tx;

    logic clk;
    logic rst;
    logic a_ser, a_busy;
    logic b_ser, b_busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    ama_riscv_uart_tx_if if_a ();
    ama_riscv_uart_tx_if if_b ();

    ama_riscv_uart_tx #(
        .CLOCK_FREQ (100_000_000),
        .BAUD_RATE  (10_000_000)
    ) dut_a (
        .clk           (clk),
        .rst           (rst),
        .uart_send_req (if_a),
        .serial_out    (a_ser),
        .tx_busy       (a_busy)
    );

    ama_riscv_uart_tx #(
        .CLOCK_FREQ (100_000_000),
        .BAUD_RATE  (50_000_000)
    ) dut_b (
        .clk           (clk),
        .rst           (rst),
        .uart_send_req (if_b),
        .serial_out    (b_ser),
        .tx_busy       (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    // Decodes frames on the 10-clock/bit line at mid-bit and pops the scoreboard.
    bit         mon_act = 1'b0;
    int         mon_cnt = 0;
    int         mon_bit = 0;
    logic [7:0] mon_byte = '0;
    logic [7:0] mon_exp;
    always @(negedge clk) begin
        if (rst) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (a_ser === 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % 10 == 5) begin
                mon_bit = mon_cnt / 10;
                if (mon_bit == 0) begin
                    chk("mon_start_bit", a_ser, 0);
                end else if (mon_bit <= 8) begin
                    mon_byte[mon_bit-1] = a_ser;
                end else begin
                    chk("mon_stop_bit", a_ser, 1);
                    chk("mon_queue_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        mon_exp = exp_q.pop_front();
                        chk("mon_byte", mon_byte, mon_exp);
                    end
                    mon_act = 1'b0;
                end
            end
        end
    end

    // Drives a one-cycle valid pulse; returns at the negedge after the accept edge.
    task automatic pulse(input bit on_b, input logic [7:0] d, input bit expect_accept);
        if (on_b) begin
            if_b.data  = d;
            if_b.valid = 1'b1;
        end else begin
            if_a.data  = d;
            if_a.valid = 1'b1;
            if (expect_accept) exp_q.push_back(d);
        end
        @(negedge clk);
        if_a.valid = 1'b0;
        if_b.valid = 1'b0;
    endtask

    // Called at the first negedge of the start bit; checks the whole frame level by level.
    task automatic check_frame(input logic [7:0] d, input int cpb, input bit on_b);
        logic [9:0] f;
        f = {1'b1, d, 1'b0};
        for (int i = 0; i < 10 * cpb; i++) begin
            chk(on_b ? "frame_b_line" : "frame_a_line", on_b ? b_ser : a_ser, f[i / cpb]);
            chk(on_b ? "frame_b_busy" : "frame_a_busy", on_b ? b_busy : a_busy, 1);
            @(negedge clk);
        end
        chk(on_b ? "frame_b_end_idle" : "frame_a_end_idle",
            on_b ? {b_ser, b_busy} : {a_ser, a_busy}, 2'b10);
    endtask

    initial begin
        logic [9:0] fa5;
        logic [9:0] f3c;
        logic [7:0] tmp;

        rst        = 1'b1;
        if_a.valid = 1'b0;
        if_a.data  = '0;
        if_b.valid = 1'b0;
        if_b.data  = '0;
        fa5 = {1'b1, 8'hA5, 1'b0};
        f3c = {1'b1, 8'h3C, 1'b0};

        // Reset, then 50 idle cycles
        repeat (3) @(negedge clk);
        chk("reset_a", {a_ser, if_a.ready, a_busy}, 3'b110);
        chk("reset_b", {b_ser, if_b.ready, b_busy}, 3'b110);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("idle_a", {a_ser, if_a.ready, a_busy}, 3'b110);
            chk("idle_b", {b_ser, if_b.ready, b_busy}, 3'b110);
        end

        // Single 0x55
        pulse(1'b0, 8'h55, 1'b1);
        chk("accept_ready_low", if_a.ready, 0);
        chk("accept_line_high", a_ser, 1);
        @(negedge clk);
        chk("load_ready_back", if_a.ready, 1);
        check_frame(8'h55, 10, 1'b0);

        // 0xA5 then 0x3C back-to-back, 0xFF dropped mid-frame
        repeat (3) @(negedge clk);
        pulse(1'b0, 8'hA5, 1'b1);
        chk("a5_accept_ready_low", if_a.ready, 0);
        @(negedge clk);
        for (int i = 0; i <= 200; i++) begin
            if (i == 0) chk("b2b_ready_before_3c", if_a.ready, 1);
            else if (i < 100) chk("b2b_ready_held_low", if_a.ready, 0);
            else chk("b2b_ready_after_load", if_a.ready, 1);
            if (i < 200) begin
                tmp = 8'(i < 100 ? fa5 >> (i / 10) : f3c >> ((i - 100) / 10));
                chk("b2b_line", a_ser, tmp[0]);
                chk("b2b_busy", a_busy, 1);
            end else begin
                chk("b2b_end_idle", {a_ser, a_busy}, 2'b10);
            end
            if (i == 0) begin
                if_a.data  = 8'h3C;
                if_a.valid = 1'b1;
                exp_q.push_back(8'h3C);
            end else if (i == 50) begin
                if_a.data  = 8'hFF;
                if_a.valid = 1'b1;
            end else begin
                if_a.valid = 1'b0;
            end
            @(negedge clk);
        end

        // Reset 45 cycles into a 0x00 frame, then 0x81
        repeat (3) @(negedge clk);
        pulse(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 45; i++) begin
            chk("zero_frame_line", a_ser, 0);
            @(negedge clk);
        end
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("midframe_reset", {a_ser, if_a.ready, a_busy}, 3'b110);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_reset_idle", {a_ser, if_a.ready, a_busy}, 3'b110);
        end
        pulse(1'b0, 8'h81, 1'b1);
        chk("81_ready_low", if_a.ready, 0);
        @(negedge clk);
        check_frame(8'h81, 10, 1'b0);

        // Two clocks per bit, 0x80
        pulse(1'b1, 8'h80, 1'b0);
        chk("b_accept_ready_low", if_b.ready, 0);
        @(negedge clk);
        chk("b_load_ready_back", if_b.ready, 1);
        check_frame(8'h80, 2, 1'b1);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("a_idle_at_end", {a_ser, if_a.ready, a_busy}, 3'b110);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
